// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor and its resolve queue.
package branch_pkg;

   // Default BHT index width (predictor PC slice).
   localparam int LOWER_DEF = 5;

   // Width of one queue entry: {index, predicted taken}.
   localparam int ENTRY_W = LOWER_DEF + 1;

   // Two-bit saturating predictor states, shared with the BHT.
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_state_t;

   // Queue fill state, derived from the entry count.
   typedef enum logic [1:0] {
      Q_EMPTY   = 2'b00,
      Q_PARTIAL = 2'b01,
      Q_FULL    = 2'b10
   } q_state_t;

   // Entry width for an arbitrary index width.
   function automatic int entry_width(input int lower);
      return lower + 1;
   endfunction

endpackage

// File: rtl/brq_fifo_mem.sv
// Register array holding queued branch predictions; head entry read combinationally.
module brq_fifo_mem
   import branch_pkg::*;
#(
   parameter int WIDTH = ENTRY_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: contents are not reset, only pointers/count are.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions between fetch and execute.
module branch_resolve_queue
   import branch_pkg::*;
#(
   parameter int LOWER = LOWER_DEF,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   pred_valid,
   input  logic [LOWER-1:0]       pred_index,
   input  logic                   pred_taken,
   output logic                   pred_ready,
   input  logic                   res_valid,
   input  logic                   res_taken,
   input  logic                   res_jumped,
   output logic                   upd_en,
   output logic [LOWER-1:0]       upd_addr,
   output logic                   upd_taken,
   output logic                   mispredict,
   output logic                   underflow_err,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [CNT_W-1:0]       hit_count,
   output logic [CNT_W-1:0]       miss_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int EW    = entry_width(LOWER);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PTR_W:0]   count_reg, count_next;
   q_state_t         state_reg, state_next;

   logic             push, resolve, actual, miss, wr_en;
   logic [EW-1:0]    head;
   logic [LOWER-1:0] head_index;
   logic             head_taken;

   brq_fifo_mem #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_reg),
      .wdata ({pred_index, pred_taken}),
      .raddr (rd_ptr_reg),
      .rdata (head)
   );

   assign head_index = head[EW-1:1];
   assign head_taken = head[0];
   assign pred_ready = (count_reg != FULL_CNT);
   assign occupancy  = count_reg;

   // Handshake decode and pointer/count next-state; a mispredict flushes and drops any push.
   always_comb begin
      push        = pred_valid & pred_ready;
      resolve     = res_valid & (state_reg != Q_EMPTY);
      actual      = res_taken | res_jumped;
      miss        = resolve & (head_taken != actual);
      wr_en       = push & ~miss;
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (miss) begin
         rd_ptr_next = wr_ptr_reg;
         count_next  = '0;
      end else begin
         if (push)    wr_ptr_next = wr_ptr_reg + PTR_ONE;
         if (resolve) rd_ptr_next = rd_ptr_reg + PTR_ONE;
         if (push && !resolve)      count_next = count_reg + CNT_ONE;
         else if (!push && resolve) count_next = count_reg - CNT_ONE;
      end
   end

   // Fill-state transitions, tracking the entry count.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         Q_EMPTY: begin
            if (push) state_next = Q_PARTIAL;
         end
         Q_PARTIAL: begin
            if (miss)                        state_next = Q_EMPTY;
            else if (count_next == FULL_CNT) state_next = Q_FULL;
            else if (count_next == '0)       state_next = Q_EMPTY;
         end
         Q_FULL: begin
            if (miss)         state_next = Q_EMPTY;
            else if (resolve) state_next = Q_PARTIAL;
         end
         default: state_next = Q_EMPTY;
      endcase
   end

   // Queue pointers, count and fill state.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         state_reg  <= Q_EMPTY;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         state_reg  <= state_next;
      end
   end

   // Registered BHT update, flush pulse, sticky underflow and saturating statistics.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         upd_en        <= 1'b0;
         upd_addr      <= '0;
         upd_taken     <= 1'b0;
         mispredict    <= 1'b0;
         underflow_err <= 1'b0;
         hit_count     <= '0;
         miss_count    <= '0;
      end else begin
         upd_en     <= resolve;
         mispredict <= miss;
         if (resolve) begin
            upd_addr  <= head_index;
            upd_taken <= actual;
         end
         if (res_valid && state_reg == Q_EMPTY) underflow_err <= 1'b1;
         if (resolve && !miss && hit_count != '1)  hit_count  <= hit_count + STAT_ONE;
         if (miss && miss_count != '1)             miss_count <= miss_count + STAT_ONE;
      end
   end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue; a second instance with 2-bit counters checks saturation.
module tb_branch_resolve_queue;

   logic       clk = 1'b0;
   logic       arst;
   logic       pred_valid;
   logic [4:0] pred_index;
   logic       pred_taken;
   logic       res_valid;
   logic       res_taken;
   logic       res_jumped;

   logic        pred_ready, upd_en, upd_taken, mispredict, underflow_err;
   logic [4:0]  upd_addr;
   logic [2:0]  occupancy;
   logic [15:0] hit_count, miss_count;

   logic        pred_ready_s, upd_en_s, upd_taken_s, mispredict_s, underflow_err_s;
   logic [4:0]  upd_addr_s;
   logic [2:0]  occupancy_s;
   logic [1:0]  hit_count_s, miss_count_s;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   branch_resolve_queue #(.LOWER(5), .DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .arst(arst),
      .pred_valid(pred_valid), .pred_index(pred_index), .pred_taken(pred_taken),
      .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_jumped(res_jumped),
      .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken),
      .mispredict(mispredict), .underflow_err(underflow_err),
      .occupancy(occupancy), .hit_count(hit_count), .miss_count(miss_count)
   );

   branch_resolve_queue #(.LOWER(5), .DEPTH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .arst(arst),
      .pred_valid(pred_valid), .pred_index(pred_index), .pred_taken(pred_taken),
      .pred_ready(pred_ready_s),
      .res_valid(res_valid), .res_taken(res_taken), .res_jumped(res_jumped),
      .upd_en(upd_en_s), .upd_addr(upd_addr_s), .upd_taken(upd_taken_s),
      .mispredict(mispredict_s), .underflow_err(underflow_err_s),
      .occupancy(occupancy_s), .hit_count(hit_count_s), .miss_count(miss_count_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int e;
      arst = 1'b1; pred_valid = 1'b0; pred_index = '0; pred_taken = 1'b0;
      res_valid = 1'b0; res_taken = 1'b0; res_jumped = 1'b0;
      tick();
      tick();
      check("rst_occ",   occupancy, 0);
      check("rst_ready", pred_ready, 1);
      check("rst_upd",   upd_en, 0);
      check("rst_mis",   mispredict, 0);
      check("rst_uflow", underflow_err, 0);
      check("rst_hit",   hit_count, 0);
      check("rst_miss",  miss_count, 0);
      arst = 1'b0;
      tick();

      // Single correct resolve
      pred_valid = 1'b1; pred_index = 5'd5; pred_taken = 1'b1;
      tick();
      pred_valid = 1'b0;
      $display("push idx=5 taken=1 occ=%0d", occupancy);
      check("one_occ", occupancy, 1);
      res_valid = 1'b1; res_taken = 1'b1;
      tick();
      res_valid = 1'b0; res_taken = 1'b0;
      $display("resolve taken=1 upd_en=%0b addr=%0d", upd_en, upd_addr);
      check("one_upd_en",  upd_en, 1);
      check("one_addr",    upd_addr, 5);
      check("one_taken",   upd_taken, 1);
      check("one_mis",     mispredict, 0);
      check("one_hit",     hit_count, 1);
      check("one_occ0",    occupancy, 0);
      tick();
      check("one_pulse",   upd_en, 0);
      check("one_hold",    upd_addr, 5);

      // Fill to DEPTH; indices 1..4, predicted taken = index bit 0
      for (int k = 1; k <= 4; k++) begin
         pred_valid = 1'b1; pred_index = 5'(k); pred_taken = k[0];
         tick();
         $display("push idx=%0d taken=%0b occ=%0d", k, k[0], occupancy);
         check("fill_occ", occupancy, 32'(k));
      end
      check("full_ready", pred_ready, 0);
      pred_index = 5'd6; pred_taken = 1'b0;
      tick();
      pred_valid = 1'b0;
      $display("push idx=6 while full occ=%0d", occupancy);
      check("full_ignore", occupancy, 4);
      res_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         res_taken = k[0];
         tick();
         $display("resolve upd_addr=%0d mis=%0b", upd_addr, mispredict);
         check("drain_en",   upd_en, 1);
         check("drain_addr", upd_addr, 32'(k));
         check("drain_mis",  mispredict, 0);
      end
      res_valid = 1'b0; res_taken = 1'b0;
      check("drain_occ",  occupancy, 0);
      check("drain_hit",  hit_count, 5);
      check("sat_hit",    hit_count_s, 3);
      tick();
      check("drain_idle", upd_en, 0);

      // Mispredict flush with a same-cycle wrong-path push
      pred_valid = 1'b1; pred_index = 5'd7; pred_taken = 1'b0;
      tick();
      pred_index = 5'd9; pred_taken = 1'b1;
      tick();
      check("mp_occ2", occupancy, 2);
      pred_index = 5'd12; pred_taken = 1'b0;
      res_valid = 1'b1; res_jumped = 1'b1;
      tick();
      pred_valid = 1'b0; res_valid = 1'b0; res_jumped = 1'b0;
      $display("resolve jump upd_addr=%0d mis=%0b occ=%0d", upd_addr, mispredict, occupancy);
      check("mp_addr",  upd_addr, 7);
      check("mp_taken", upd_taken, 1);
      check("mp_mis",   mispredict, 1);
      check("mp_occ",   occupancy, 0);
      check("mp_miss",  miss_count, 1);
      check("mp_hit",   hit_count, 5);
      tick();
      check("mp_pulse", mispredict, 0);

      // Simultaneous push/resolve at occupancy 2 across pointer wrap
      exp_q.delete();
      pred_valid = 1'b1; pred_index = 5'd10; pred_taken = 1'b1;
      exp_q.push_back(10 * 2 + 1);
      tick();
      pred_index = 5'd11; pred_taken = 1'b0;
      exp_q.push_back(11 * 2 + 0);
      tick();
      for (int k = 0; k < 8; k++) begin
         pred_index = 5'(16 + k); pred_taken = k[0];
         e = exp_q.pop_front();
         res_valid = 1'b1; res_taken = e[0];
         exp_q.push_back((16 + k) * 2 + int'(k[0]));
         tick();
         $display("push idx=%0d + resolve upd_addr=%0d occ=%0d", 16 + k, upd_addr, occupancy);
         check("pair_addr", upd_addr, 32'(e >> 1));
         check("pair_mis",  mispredict, 0);
         check("pair_occ",  occupancy, 2);
      end
      pred_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         e = exp_q.pop_front();
         res_taken = e[0];
         tick();
         $display("resolve upd_addr=%0d", upd_addr);
         check("tail_addr", upd_addr, 32'(e >> 1));
      end
      res_valid = 1'b0; res_taken = 1'b0;
      check("pair_drain", occupancy, 0);
      check("pair_hit",   hit_count, 15);
      check("sat_hit2",   hit_count_s, 3);
      check("sat_miss",   miss_count_s, 1);

      // Resolve while empty
      res_valid = 1'b1; res_taken = 1'b1;
      tick();
      res_valid = 1'b0; res_taken = 1'b0;
      $display("resolve empty uflow=%0b", underflow_err);
      check("uf_upd",  upd_en, 0);
      check("uf_flag", underflow_err, 1);
      check("uf_hit",  hit_count, 15);
      tick();
      tick();
      check("uf_sticky", underflow_err, 1);

      // Asynchronous reset with 3 entries queued and a resolve pending
      for (int k = 0; k < 3; k++) begin
         pred_valid = 1'b1; pred_index = 5'(20 + k); pred_taken = 1'b1;
         tick();
      end
      pred_valid = 1'b0;
      check("pre_rst_occ", occupancy, 3);
      res_valid = 1'b1; res_taken = 1'b1;
      arst = 1'b1;
      #1;
      $display("async reset occ=%0d", occupancy);
      check("arst_occ",   occupancy, 0);
      check("arst_ready", pred_ready, 1);
      check("arst_hit",   hit_count, 0);
      check("arst_miss",  miss_count, 0);
      check("arst_uflow", underflow_err, 0);
      tick();
      check("arst_upd",   upd_en, 0);
      res_valid = 1'b0; res_taken = 1'b0;
      arst = 1'b0;
      tick();
      check("post_upd", upd_en, 0);

      // Normal operation after reset
      pred_valid = 1'b1; pred_index = 5'd3; pred_taken = 1'b1;
      tick();
      pred_valid = 1'b0;
      res_valid = 1'b1; res_taken = 1'b1;
      tick();
      res_valid = 1'b0; res_taken = 1'b0;
      $display("resolve after reset upd_addr=%0d", upd_addr);
      check("post_addr", upd_addr, 3);
      check("post_hit",  hit_count, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight branch predictions, sitting between fetch and execute.
- Fetch pushes each predicted branch: BHT index plus predicted direction. Execute resolves branches oldest-first.
- The queue produces the registered BHT update (enable, write address, actual outcome), a mispredict pulse that drives the pipeline flush, and hit/miss statistics.
- Mispredict flushes all younger, wrong-path entries.

Parameters:
- LOWER, 5, BHT index width in bits; matches the predictor's PC slice.
- DEPTH, 4, queue entries; power of two, minimum 2.
- CNT_W, 16, width of the hit and miss statistics counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- arst  input  1  asynchronous, active-high reset.
- pred_valid  input  1  fetch presents a predicted branch.
- pred_index  input  LOWER  BHT index of that branch.
- pred_taken  input  1  predicted direction (1 = taken).
- pred_ready  output  1  queue not full; combinational from count.
- res_valid  input  1  execute resolves the oldest outstanding branch.
- res_taken  input  1  conditional branch actually taken.
- res_jumped  input  1  unconditional jump executed.
- upd_en  output  1  registered BHT update strobe.
- upd_addr  output  LOWER  index to update (head entry's pred_index).
- upd_taken  output  1  actual outcome = res_taken | res_jumped.
- mispredict  output  1  registered one-cycle flush pulse.
- underflow_err  output  1  sticky; set when res_valid arrives while the queue is empty.
- occupancy  output  log2(DEPTH)+1  current entry count.
- hit_count  output  CNT_W  saturating count of correct predictions.
- miss_count  output  CNT_W  saturating count of mispredictions.

Behaviour:
- Reset (arst=1, asynchronous):
  - Pointers, count and both stats counters cleared to 0.
  - upd_en=0, upd_addr=0, upd_taken=0, mispredict=0, underflow_err=0.
  - pred_ready=1.
  - Entry storage contents need not be reset.
  - Reset asserted mid-operation discards all entries immediately; no update pulse is emitted for them.
- Storage: DEPTH entries of {index, taken}.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits; occupancy = count.
- Push: a push occurs when pred_valid & pred_ready. When full, pred_ready=0 and pred_valid is ignored; no entry is overwritten.
- Resolve: a resolve occurs when res_valid & count!=0.
  - actual = res_taken | res_jumped.
  - miss = head.taken != actual.
  - Next cycle: upd_en=1, upd_addr=head.index, upd_taken=actual, mispredict=miss. Latency is exactly 1 cycle.
  - Otherwise upd_en=0 and mispredict=0. upd_addr and upd_taken hold their last value.
- Resolve on a correct prediction: rd_ptr advances and count decrements. If a push happens in the same cycle, count is unchanged. A same-cycle push is accepted even when full, because pred_ready is computed from the current count.
  - Correction: pred_ready is strictly !full; a push in the same cycle as a resolve is not allowed while full.
- Resolve on a mispredict: the whole queue flushes.
  - count=0 and rd_ptr=wr_ptr.
  - Any push in the same cycle is dropped; fetch is on the wrong path.
- Empty resolve: res_valid with count=0 causes no update and sets underflow_err, which stays set until reset.
- Statistics: hit_count increments on a correct resolve and miss_count on a mispredict. Both saturate at all-ones.
- FSM:
  - States: EMPTY, PARTIAL, FULL, derived from count.
  - EMPTY→PARTIAL on a push.
  - PARTIAL→FULL when count reaches DEPTH.
  - FULL→PARTIAL on a correct resolve.
  - Any state→EMPTY on a mispredict, or on a resolve when count=1 with no push.

Decomposition:
- Shared package (branch_pkg): LOWER default, a typedef-equivalent entry width (LOWER+1), and the predictor-state encodings SNT=00, WNT=01, WT=10, ST=11, shared with the branch history table.
- One natural sub-module: brq_fifo_mem, the DEPTH×(LOWER+1) register array with write port and asynchronous read of the head entry.
- Control, pointers and counters stay in the top module.

Test Plan:
- Reset check: assert arst mid-stream with 3 entries queued → occupancy=0, pred_ready=1, no upd_en pulse, both counters 0.
- Correct resolve: push {index 5, taken 1}, then res_valid with res_taken=1 → next cycle upd_en=1, upd_addr=5, upd_taken=1, mispredict=0, hit_count=1.
- Fill: push 4 entries (indices 1,2,3,4) → pred_ready=0 and a 5th push is ignored. Resolving all 4 correctly gives upd_addr 1,2,3,4 in order, each one cycle after its res_valid.
- Mispredict flush: queue {7 taken 0, 9 taken 1}, resolve with res_jumped=1 while pushing index 12 → upd_addr=7, upd_taken=1, mispredict=1, occupancy=0 (index 12 dropped), miss_count=1.
- Simultaneous push and correct resolve at occupancy 2 → occupancy stays 2; FIFO order is preserved across pointer wrap after 8 further push/resolve pairs.
- Underflow and saturation: res_valid while empty → underflow_err=1 and sticky, no upd_en. With CNT_W=2, 5 correct resolves → hit_count=3.
